// File: rtl/mips_pkg.sv
// Shared MIPS constants for the IF/ID hazard slice.
// Opcodes, decode field positions and the canonical nop.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // rt is a source register only for these formats
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) ||
           (op == OP_BNE)   || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use check of the IF/ID instruction
// against the load currently in ID/EX.
module load_use_detect
  import mips_pkg::*;
(
  input  logic        valid_out,
  input  logic [31:0] instr_out,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  output logic        hazard
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_low;

  assign op = instr_out[OP_HI:OP_LO];
  assign rs = instr_out[RS_HI:RS_LO];
  assign rt = instr_out[RT_HI:RT_LO];
  assign unused_low = ^instr_out[15:0];

  assign rs_hit = (id_ex_rt == rs);
  assign rt_hit = uses_rt(op) && (id_ex_rt == rt);

  assign hazard = valid_out && id_ex_mem_read &&
                  (id_ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID register with load-use stall, branch flush
// and saturating stall/flush counters.
module if_id_hazard_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_4_in,
  input  logic [31:0]      instr_in,
  input  logic             flush,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  output logic [31:0]      pc_4_out,
  output logic [31:0]      instr_out,
  output logic             valid_out,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic hazard;
  logic stall;

  load_use_detect u_detect (
    .valid_out      (valid_out),
    .instr_out      (instr_out),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .hazard         (hazard)
  );

  // flush wins: squashing the slot removes the hazard
  assign stall       = hazard & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign bubble      = stall | flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_4_out  <= 32'h0;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else begin
      unique case (1'b1)
        flush: begin
          pc_4_out  <= 32'h0;
          instr_out <= NOP_INSTR;
          valid_out <= 1'b0;
        end
        stall: begin
          pc_4_out  <= pc_4_out;
          instr_out <= instr_out;
          valid_out <= valid_out;
        end
        default: begin
          pc_4_out  <= pc_4_in;
          instr_out <= instr_in;
          valid_out <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_ONE;
      if (flush && flush_count != CNT_MAX)
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Scoreboard bench for if_id_hazard_stage: directed
// cases, random traffic, counter saturation, async reset.
module tb_if_id_hazard_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_4_in;
  logic [31:0] instr_in;
  logic        flush;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic [31:0] pc_4_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        pc_write;
  logic        if_id_write;
  logic        bubble;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  if_id_hazard_stage #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_4_in        (pc_4_in),
    .instr_in       (instr_in),
    .flush          (flush),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .pc_4_out       (pc_4_out),
    .instr_out      (instr_out),
    .valid_out      (valid_out),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .bubble         (bubble),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        vld;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic        m_vld;
  logic [15:0] m_sc;
  logic [15:0] m_fc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_hazard(input logic mr,
                                    input logic [4:0] rt);
    logic [5:0] op;
    logic       use_rt;
    op     = m_ins[31:26];
    use_rt = (op == 6'h00) || (op == 6'h04) ||
             (op == 6'h05) || (op == 6'h2B);
    return m_vld && mr && (rt != 5'd0) &&
           ((rt == m_ins[25:21]) ||
            (use_rt && rt == m_ins[20:16]));
  endfunction

  // drive one cycle, check comb outputs, score the edge
  task automatic step(input logic [31:0] pc,
                      input logic [31:0] ins,
                      input logic fl,
                      input logic mr,
                      input logic [4:0] rt);
    logic st;
    exp_t e;
    exp_t g;
    pc_4_in        = pc;
    instr_in       = ins;
    flush          = fl;
    id_ex_mem_read = mr;
    id_ex_rt       = rt;
    #1;
    st = m_hazard(mr, rt) && !fl;
    chk("pc_write", {31'd0, pc_write}, {31'd0, !st});
    chk("if_id_write", {31'd0, if_id_write}, {31'd0, !st});
    chk("bubble", {31'd0, bubble}, {31'd0, st || fl});
    if (fl) begin
      m_pc = 0; m_ins = 0; m_vld = 0;
    end else if (!st) begin
      m_pc = pc; m_ins = ins; m_vld = 1;
    end
    if (st && m_sc != 16'hFFFF) m_sc++;
    if (fl && m_fc != 16'hFFFF) m_fc++;
    e.pc = m_pc; e.ins = m_ins; e.vld = m_vld;
    e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("pc_4_out", pc_4_out, g.pc);
    chk("instr_out", instr_out, g.ins);
    chk("valid_out", {31'd0, valid_out}, {31'd0, g.vld});
    chk("stall_count", {16'd0, stall_count}, {16'd0, g.sc});
    chk("flush_count", {16'd0, flush_count}, {16'd0, g.fc});
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] ops [6];
    ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
    ops[3] = 6'h23; ops[4] = 6'h2B; ops[5] = 6'h08;
    return {ops[$urandom_range(0, 5)],
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            16'($urandom)};
  endfunction

  initial begin
    rst_n = 1'b0;
    pc_4_in = 0; instr_in = 0; flush = 0;
    id_ex_mem_read = 0; id_ex_rt = 0;
    m_pc = 0; m_ins = 0; m_vld = 0; m_sc = 0; m_fc = 0;
    #12;
    chk("rst_pc", pc_4_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("rst_bubble", {31'd0, bubble}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(32'h04, 32'h012A4020, 0, 0, 5'd0);
    step(32'h08, 32'h01095020, 0, 0, 5'd0);
    step(32'h0C, 32'h8D280004, 0, 1, 5'd8);
    step(32'h0C, 32'h8D280004, 0, 0, 5'd0);
    step(32'h10, 32'h8D280004, 0, 1, 5'd8);
    step(32'h14, 32'h01095020, 0, 1, 5'd0);
    step(32'h18, 32'h012A4020, 1, 1, 5'd8);
    step(32'h1C, 32'h01095020, 0, 1, 5'd8);
    step(32'h20, 32'h8D280004, 0, 1, 5'd9);
    step(32'h20, 32'h8D280004, 0, 0, 5'd0);
    step(32'h24, 32'h01095020, 0, 1, 5'd8);
    step(32'h28, 32'h8D490000, 0, 0, 5'd0);
    step(32'h2C, 32'h012A4020, 0, 1, 5'd9);

    for (int i = 0; i < 60; i++)
      step(32'($urandom), rnd_instr(),
           ($urandom_range(0, 5) == 0),
           1'($urandom), 5'($urandom_range(0, 3)));

    step(32'h40, 32'h01095020, 0, 0, 5'd0);
    pc_4_in = 32'h44;
    instr_in = 32'h00000000;
    id_ex_mem_read = 1'b1;
    id_ex_rt = 5'd8;
    for (int i = 0; i < 65539; i++) @(posedge clk);
    #1;
    chk("sat_stall_count", {16'd0, stall_count}, 32'h0000FFFF);
    chk("sat_instr_held", instr_out, 32'h01095020);
    chk("sat_pc_held", pc_4_out, 32'h40);
    chk("sat_pc_write", {31'd0, pc_write}, 32'd0);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_4_out, 32'h0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    chk("arst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("arst_flush_count", {16'd0, flush_count}, 32'd0);
    chk("arst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("arst_bubble", {31'd0, bubble}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_stage.md
# if_id_hazard_stage

IF/ID pipeline register merged with load-use hazard detection for the 5-stage MIPS pipeline. It captures the fetched instruction and PC+4 each cycle and presents them to decode. It detects a load-use dependency against the instruction currently in ID/EX and holds PC and IF/ID for one cycle while a control bubble is injected into ID/EX. Branch flushes from downstream squash the held instruction, and saturating stall and flush counters support performance debug.

## Interface
- `CNT_W`, 16, width of the performance counters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_4_in`  in  32  PC+4 from fetch.
- `instr_in`  in  32  fetched instruction.
- `flush`  in  1  taken branch resolved downstream; squash IF/ID.
- `id_ex_mem_read`  in  1  MemRead currently held in the ID/EX register.
- `id_ex_rt`  in  5  rt currently held in the ID/EX register.
- `pc_4_out`  out  32  registered PC+4 to decode.
- `instr_out`  out  32  registered instruction to decode.
- `valid_out`  out  1  IF/ID holds a real instruction.
- `pc_write`  out  1  PC may update this cycle.
- `if_id_write`  out  1  IF/ID loads this cycle (informational; equals `pc_write`).
- `bubble`  out  1  ID/EX must capture all-zero control this cycle.
- `stall_count`  out  CNT_W  stall cycles since reset, saturating.
- `flush_count`  out  CNT_W  flush cycles since reset, saturating.

## Operation
- Decode fields of `instr_out`:
  - op = [31:26]
  - rs = [25:21]
  - rt = [20:16]
- `uses_rt` is 1 for op 0x00 (R-type), 0x04 (beq), 0x05 (bne) and 0x2B (sw).
- `hazard` = `valid_out` & `id_ex_mem_read` & (`id_ex_rt` != 0) & ((`id_ex_rt` == rs) | (`uses_rt` & `id_ex_rt` == rt)).
- `stall` = `hazard` & ~`flush`.
- Combinational outputs:
  - `pc_write` = ~`stall`
  - `if_id_write` = ~`stall`
  - `bubble` = `stall` | `flush`
- Register update priority on each clock edge: flush > stall > load.
  - flush: `instr_out` = 0 (sll $0 nop), `pc_4_out` = 0, `valid_out` = 0.
  - stall: all three registers hold.
  - load: `instr_out` = `instr_in`, `pc_4_out` = `pc_4_in`, `valid_out` = 1.
- Stall length:
  - A load-use stall lasts exactly one cycle.
  - The bubble clears ID/EX MemRead on the next edge, so `hazard` falls without further logic.
- Counters:
  - `stall_count` increments on each cycle with `stall`=1.
  - `flush_count` increments on each cycle with `flush`=1.
  - Both hold at all-ones (no wrap).
- Boundary cases:
  - `id_ex_rt`=0 never stalls ($zero).
  - An invalid (flushed) slot never stalls.
  - Flush and hazard in the same cycle: flush only, `pc_write`=1.

## Timing
- Reset (asynchronous, on `rst_n` low, independent of `clk`): `pc_4_out`, `instr_out`, `valid_out`, `stall_count` and `flush_count` all go to 0.
- While `rst_n` is low the combinational outputs are `pc_write`=1, `if_id_write`=1, `bubble`=0, because `valid_out`=0 and `flush` is not considered part of reset.
- Deassertion of `rst_n` is expected synchronous to `clk`; the first edge after release loads fetch.
- Latency: one cycle from `instr_in` to `instr_out`.
- `stall`, `pc_write` and `bubble` are combinational from the current-cycle register contents and inputs, and are valid before the next edge.
- Reset mid-stall: the hold is abandoned and the counters clear.
- Back-to-back load-use (lw then dependent, then another lw plus dependent) costs one stall per pair.
- No combinational path from `instr_in` to any output.

## Structure
- Shared package `mips_pkg`:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW
  - field bit-position constants
  - NOP_INSTR = 32'h0
- Sub-module `load_use_detect`: purely combinational; inputs `valid_out`, `instr_out`, `id_ex_mem_read`, `id_ex_rt`; output `hazard`.
- The top level holds the registers, the priority mux and the two saturating counters.

## Test plan
- Reset then load: reset, then present pc_4_in=0x04, instr_in=0x012A4020 (add $8,$9,$10) -> after one edge `instr_out`=0x012A4020, `valid_out`=1, `pc_write`=1.
- Load-use on rs: `instr_out`=0x01095020 (add $10,$8,$9), `id_ex_mem_read`=1, `id_ex_rt`=8 -> `stall`=1, `pc_write`=0, `bubble`=1, IF/ID holds one edge, `stall_count`=1.
- No stall for I-type on rt or $zero: `instr_out`=0x8D280004 (lw $8,4($9)) with `id_ex_rt`=8 -> `pc_write`=1. The same `instr_out` with `id_ex_rt`=0 -> `pc_write`=1.
- Flush with simultaneous hazard: the hazard case above plus `flush`=1 -> `pc_write`=1, `bubble`=1, next `instr_out`=0, `valid_out`=0, `flush_count`=1, `stall_count` unchanged.
- Counter saturation: force 2^CNT_W+3 stall cycles -> `stall_count`=0xFFFF, no wrap.
- Async reset mid-stall: drop `rst_n` between edges during a stall -> all registered outputs are 0 immediately and `pc_write`=1.
